// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GUARD
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;

  // Anodes are active low: all ones turns every digit off.
  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

  // Segment pattern the downstream decoder emits for "nothing lit".
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Reference hex decoder (active-low gfedcba), as used next to this block.
  function automatic logic [6:0] hex2seg(input logic [DIGIT_W-1:0] d);
    case (d)
      4'h0: hex2seg = 7'b1000000;
      4'h1: hex2seg = 7'b1111001;
      4'h2: hex2seg = 7'b0100100;
      4'h3: hex2seg = 7'b0110000;
      4'h4: hex2seg = 7'b0011001;
      4'h5: hex2seg = 7'b0010010;
      4'h6: hex2seg = 7'b0000010;
      4'h7: hex2seg = 7'b1111000;
      4'h8: hex2seg = 7'b0000000;
      4'h9: hex2seg = 7'b0010000;
      4'hA: hex2seg = 7'b0001000;
      4'hB: hex2seg = 7'b0000011;
      4'hC: hex2seg = 7'b1000110;
      4'hD: hex2seg = 7'b0100001;
      4'hE: hex2seg = 7'b0000110;
      4'hF: hex2seg = 7'b0001110;
      default: hex2seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Load handshake between a value producer and the scan controller.
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  import seg7_pkg::*;

  logic                          load_valid;
  logic [DIGIT_W*NUM_DIGITS-1:0] load_data;
  logic                          load_ready;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg7_slot_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module seg7_slot_timer #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [TW-1:0] len_m1,
  output logic          done
);

  logic [TW-1:0] cnt;

  // Load slot length minus one, then count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (load)       cnt <= len_m1;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed hex display scanner with frame-aligned value swap, blanking,
// leading-zero suppression and an all-dark guard interval between digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000,
  parameter int GUARD_CYC  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  seg7_scan_ctrl_if.slave       lif,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  input  logic                  lz_en,
  output logic [DIGIT_W-1:0]    digit_code,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_start
);

  // Counter must hold the longer of the two slot lengths.
  localparam int CW = $clog2(CLK_DIV > GUARD_CYC ? CLK_DIV : GUARD_CYC);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0]         LAST    = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_DARK = AN_OFF[NUM_DIGITS-1:0];

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] nib_vec_t;

  state_t          st;
  logic [IW-1:0]   idx;
  nib_vec_t        active, shadow;
  logic            pending, rdy;

  logic            t_done, t_load, t_clr;
  logic [CW-1:0]   t_len;

  logic            accept, swap, last_guard;
  nib_vec_t        active_nxt;
  logic [IW-1:0]   nxt_idx;
  logic [NUM_DIGITS-1:0] lz_dark, dark, entry_an;

  assign accept         = lif.load_valid & rdy;
  assign lif.load_ready = rdy;

  // A frame ends when the last digit's guard expires; that is the only
  // point a pending value may replace the displayed one while scanning.
  assign last_guard = (st == GUARD) && t_done && (idx == LAST);
  assign swap       = pending && ((st == IDLE) || !enable || last_guard);
  assign active_nxt = swap ? shadow : active;

  assign nxt_idx = ((st == GUARD) && (idx != LAST)) ? idx + 1'b1 : '0;

  // Digit g is a leading zero when it and every digit above it are zero;
  // digit 0 is always shown so a zero value reads "0".
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
    if (g == 0) begin : g_d0
      assign lz_dark[g] = 1'b0;
    end else begin : g_dn
      assign lz_dark[g] = lz_en && (active_nxt[NUM_DIGITS-1:g] == '0);
    end
  end

  assign dark     = blank_mask | lz_dark;
  assign entry_an = dark[nxt_idx] ? AN_DARK : ~(NUM_DIGITS'(1) << nxt_idx);

  assign t_clr = !enable;
  assign t_load = enable && ((st == IDLE) || t_done);
  assign t_len  = (st == SHOW) ? CW'(GUARD_CYC - 1) : CW'(CLK_DIV - 1);

  seg7_slot_timer #(.TW(CW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (t_clr),
    .load   (t_load),
    .len_m1 (t_len),
    .done   (t_done)
  );

  // Shadow capture on handshake, shadow-to-active copy on swap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
      rdy     <= 1'b1;
    end else if (accept) begin
      shadow  <= lif.load_data;
      pending <= 1'b1;
      rdy     <= 1'b0;
    end else if (swap) begin
      active  <= shadow;
      pending <= 1'b0;
      rdy     <= 1'b1;
    end
  end

  // Scan sequencer: IDLE -> SHOW(idx) -> GUARD -> SHOW(idx+1) ... with
  // registered anode/code outputs updated together on SHOW entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= IDLE;
      idx         <= '0;
      an_n        <= AN_DARK;
      digit_code  <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (!enable) begin
        st   <= IDLE;
        idx  <= '0;
        an_n <= AN_DARK;
      end else begin
        case (st)
          IDLE: begin
            st          <= SHOW;
            idx         <= nxt_idx;
            an_n        <= entry_an;
            digit_code  <= active_nxt[nxt_idx];
            frame_start <= 1'b1;
          end
          SHOW: begin
            if (t_done) begin
              st   <= GUARD;
              an_n <= AN_DARK;
            end
          end
          GUARD: begin
            if (t_done) begin
              st          <= SHOW;
              idx         <= nxt_idx;
              an_n        <= entry_an;
              digit_code  <= active_nxt[nxt_idx];
              frame_start <= (idx == LAST);
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench: a cycle-offset reference model predicts every output
// cycle, a monitor pops and compares on each falling clock edge.
module tb_seg7_scan_ctrl;
  localparam int ND        = 4;
  localparam int CLK_DIV   = 4;
  localparam int GUARD_CYC = 1;
  localparam int W         = 4 * ND;
  localparam int P         = CLK_DIV + GUARD_CYC;
  localparam int FRAME     = ND * P;
  localparam int IW        = $clog2(ND);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          lz_en = 1'b0;
  logic [ND-1:0] blank_mask = '0;
  logic [3:0]    digit_code;
  logic [ND-1:0] an_n;
  logic          frame_start;

  seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) lif();

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(CLK_DIV), .GUARD_CYC(GUARD_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .lif         (lif),
    .blank_mask  (blank_mask),
    .lz_en       (lz_en),
    .digit_code  (digit_code),
    .an_n        (an_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [3:0]    code;
    logic          fs;
    logic          rdy;
  } exp_t;

  exp_t expq[$];

  // Reference state: displayed value, offered value, and position in frame.
  logic [W-1:0]  m_act, m_shd;
  logic          m_pend, m_run;
  int            m_t;
  logic [ND-1:0] m_an;
  logic [3:0]    m_code;

  // Model: frame position t -> slot = t / P, phase = t % P; lit for phase < CLK_DIV.
  always @(posedge clk) begin : model
    automatic logic          acc, swp, fs, npend;
    automatic logic [W-1:0]  nact;
    automatic int            nt, ph;
    automatic logic [IW-1:0] sl;
    automatic logic [ND-1:0] an;
    automatic logic [3:0]    code;
    if (!rst_n) begin
      m_act <= '0; m_shd <= '0; m_pend <= 1'b0; m_run <= 1'b0;
      m_t <= 0; m_an <= '1; m_code <= '0;
      expq.push_back({{ND{1'b1}}, 4'h0, 1'b0, 1'b1});
    end else begin
      acc  = lif.load_valid && !m_pend;
      swp  = m_pend && (!m_run || !enable || (m_t == FRAME - 1));
      nact = swp ? m_shd : m_act;
      an = m_an; code = m_code; fs = 1'b0; nt = 0;
      if (enable) begin
        nt = m_run ? (m_t + 1) % FRAME : 0;
        sl = IW'(nt / P);
        ph = nt % P;
        if (ph == 0) begin
          if (blank_mask[sl] || (lz_en && sl != 0 && (nact >> (4 * sl)) == '0))
            an = '1;
          else
            an = ~(ND'(1) << sl);
          code = 4'(nact >> (4 * sl));
          fs   = (sl == 0);
        end else if (ph == CLK_DIV) begin
          an = '1;
        end
      end else begin
        an = '1;
      end
      npend = acc ? 1'b1 : (swp ? 1'b0 : m_pend);
      if (acc)      m_shd <= lif.load_data;
      else if (swp) m_act <= m_shd;
      m_pend <= npend;
      m_run  <= enable;
      m_t    <= nt;
      m_an   <= an;
      m_code <= code;
      expq.push_back({an, code, fs, !npend});
    end
  end

  int   checks = 0, errors = 0, timeouts = 0;
  logic rst_chk = 1'b0, tb_done = 1'b0;
  exp_t e;

  // Monitor: compares every output cycle, the instant after async reset, and the wrap-up.
  always @(negedge clk or posedge rst_chk or posedge tb_done) begin : monitor
    if (tb_done) begin
      checks++;
      if (timeouts != 0) begin
        errors++;
        $display("FAIL frame_wait timeouts=%0d expected 0", timeouts);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end else if (rst_chk) begin
      checks++;
      if ({an_n, digit_code, frame_start, lif.load_ready} !== {{ND{1'b1}}, 4'h0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL async_reset @%0t an_n=%b code=%h fs=%b rdy=%b expected 1111/0/0/1",
                 $time, an_n, digit_code, frame_start, lif.load_ready);
      end
    end else if (expq.size() != 0) begin
      e = expq.pop_front();
      checks++;
      if ({an_n, digit_code, frame_start, lif.load_ready} !== e) begin
        errors++;
        $display("FAIL scan @%0t an_n=%b exp %b code=%h exp %h fs=%b exp %b rdy=%b exp %b",
                 $time, an_n, e.an, digit_code, e.code, frame_start, e.fs, lif.load_ready, e.rdy);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs();
    int n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (frame_start !== 1'b1) begin
      timeouts++;
      $display("FAIL frame_start_wait got no pulse in 200 cycles, expected one");
    end
  endtask

  task automatic offer(input logic [W-1:0] v, input int hold, input bit churn);
    lif.load_valid = 1'b1;
    lif.load_data  = v;
    for (int i = 0; i < hold; i++) begin
      cyc(1);
      if (churn) lif.load_data = W'($urandom);
    end
    lif.load_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_val();
    return W'($urandom) >> (4 * $urandom_range(0, 3));
  endfunction

  initial begin
    lif.load_valid = 1'b0;
    lif.load_data  = '0;
    cyc(3);
    rst_n = 1'b1;

    // Basic scan of 1A3F.
    offer(16'h1A3F, 1, 1'b0);
    cyc(1);
    enable = 1'b1;
    wait_fs();
    cyc(2 * FRAME);

    // Leading-zero suppression: 0050, then 0000 loaded while scanning.
    enable = 1'b0;
    lz_en  = 1'b1;
    offer(16'h0050, 1, 1'b0);
    enable = 1'b1;
    wait_fs();
    cyc(FRAME);
    offer(16'h0000, 1, 1'b0);
    cyc(2 * FRAME);
    lz_en = 1'b0;

    // 1111 accepted mid-frame, 2222 held off until after the boundary.
    wait_fs();
    lif.load_valid = 1'b1;
    lif.load_data  = 16'h1111;
    cyc(1);
    lif.load_data  = 16'h2222;
    cyc(22);
    lif.load_valid = 1'b0;
    cyc(2 * FRAME);

    // Per-digit blanking.
    blank_mask = 4'b0100;
    wait_fs();
    offer(16'h8888, 1, 1'b0);
    cyc(2 * FRAME);
    blank_mask = '0;

    // Enable dropped during SHOW of digit 2, then restart.
    wait_fs();
    cyc(2 * P + 1);
    enable = 1'b0;
    cyc(3);
    enable = 1'b1;
    wait_fs();
    cyc(FRAME);

    // Randomized mix of loads, config changes and enable blips.
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0: begin
          enable = 1'b0;
          cyc($urandom_range(1, 3));
          blank_mask = ($urandom_range(0, 1) != 0) ? '0 : ND'($urandom);
          lz_en = 1'($urandom);
          offer(rand_val(), 1, 1'b0);
          enable = 1'b1;
        end
        1: begin
          wait_fs();
          cyc($urandom_range(0, 18));
          offer(rand_val(), $urandom_range(1, 25), 1'b1);
        end
        2: begin
          cyc($urandom_range(0, 19));
          blank_mask = ($urandom_range(0, 1) != 0) ? '0 : ND'($urandom);
          lz_en = 1'($urandom);
        end
        default: begin
          cyc($urandom_range(0, 19));
          enable = 1'b0;
          cyc($urandom_range(1, 2));
          enable = 1'b1;
        end
      endcase
      cyc($urandom_range(5, 30));
    end

    // Async reset during digit 0 guard with a value pending.
    wait_fs();
    lif.load_valid = 1'b1;
    lif.load_data  = rand_val() | 16'h0001;
    cyc(1);
    lif.load_valid = 1'b0;
    cyc(3);
    #2 rst_n = 1'b0;
    #1 rst_chk = 1'b1;
    #1 rst_chk = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(FRAME + 3);

    tb_done = 1'b1;
  end

endmodule
